adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin controller that shares one 16-bit carry-select/latch adder (`modifiedcarrylatch`) among `NREQ` requesters. It grants one requester at a time and drives the adder operands and `enable`. It waits a fixed settle time, registers `sum`/`cout`, and returns the result with a one-cycle acknowledge. It sits between the client request ports and the single adder instance, which stays purely combinational/latch-based.

## Interface

Parameters:
- `NREQ`, 4: number of requesters; 2..8.
- `WIDTH`, 16: operand width; must match the adder.
- `SETTLE`, 2: number of cycles `add_enable` is held high before capture; minimum 1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, NREQ: per-requester request level.
- `a_in`, input, NREQ*WIDTH: operand A; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `b_in`, input, NREQ*WIDTH: operand B, same packing as `a_in`.
- `gnt`, output, NREQ: one-hot grant, registered.
- `ack`, output, 1: one-cycle pulse; result valid this cycle.
- `resp_id`, output, $clog2(NREQ): index of the requester being acknowledged.
- `sum_out`, output, WIDTH: registered sum.
- `cout_out`, output, 1: registered carry-out.
- `busy`, output, 1: high in any state other than IDLE.
- `add_a`, output, WIDTH: drives the adder `a`.
- `add_b`, output, WIDTH: drives the adder `b`.
- `add_enable`, output, 1: drives the adder `enable`.
- `add_sum`, input, WIDTH: from the adder `sum`.
- `add_cout`, input, 1: from the adder `cout`.

## Operation

- States:
  - IDLE: no grant active.
  - EVAL: grant active, adder evaluating.
  - CAPTURE: result is registered.
  - RESP: `ack` is pulsed.
- IDLE: if any `req` bit is high, pick the first set bit searching upward from `ptr`, wrapping modulo NREQ.
  - Register the winner's index in `cur` and set `gnt` to the one-hot of `cur`.
  - Clear the settle counter and go to EVAL.
  - With no request, stay in IDLE.
- EVAL:
  - `add_a`/`add_b` = operands of `cur`, muxed live from `a_in`/`b_in`.
  - `add_enable` = 1, so the latches are transparent and the speculative carry-1 path is computed.
  - The counter increments each cycle. After SETTLE cycles in EVAL, go to CAPTURE.
- CAPTURE:
  - Operands are still driven and `add_enable` = 0, so the latches hold.
  - Register `sum_out` <= `add_sum` and `cout_out` <= `add_cout`.
  - Go to RESP.
- RESP:
  - `ack` = 1 and `resp_id` = `cur`.
  - `gnt` is cleared at the exit edge.
  - `ptr` <= (`cur` + 1) mod NREQ.
  - Go to IDLE.
- Abort: if `req[cur]` falls during EVAL or CAPTURE, go to IDLE at the next edge.
  - No `ack`, `sum_out`/`cout_out` unchanged, `ptr` advanced as in RESP.
- A `req` bit still high after its `ack` is treated as a new request and competes normally.
- Operands must be stable from grant until `ack`. Changes during EVAL are passed through to the adder. Changes during CAPTURE are undefined.
- Arithmetic: `sum_out` = (A + B) mod 2^WIDTH and `cout_out` = carry out of bit WIDTH-1. The controller does no arithmetic of its own.
- When not in EVAL or CAPTURE: `add_a`/`add_b` = 0 and `add_enable` = 0.

## Timing

- Reset (async, `rst_n` = 0), values held until the first edge after release:
  - State IDLE.
  - `gnt` = 0, `ack` = 0, `resp_id` = 0.
  - `sum_out` = 0, `cout_out` = 0, `busy` = 0.
  - `add_a` = 0, `add_b` = 0, `add_enable` = 0.
  - `ptr` = 0, counter = 0.
- Reset mid-operation: immediate return to IDLE. No `ack` is issued and the result registers clear.
- Let cycle 0 be the IDLE cycle in which `req` is sampled:
  - `gnt` and `busy` rise in cycle 1.
  - EVAL spans cycles 1..SETTLE.
  - CAPTURE is cycle SETTLE+1.
  - `ack` is high in cycle SETTLE+2, with `sum_out` valid from that cycle until the next capture.
- `gnt` falls and the state returns to IDLE in cycle SETTLE+3. The next grant can appear in cycle SETTLE+4.
- Throughput: one operation per SETTLE+3 cycles.
- `ack` is never high for two consecutive cycles.
- `gnt` is never multi-hot.
- Simultaneous requests: resolved purely by `ptr`. A requester asserting `req` while another is busy waits, and is served after at most NREQ-1 other operations.

## Test plan

- Single operation: reset, then `req[0]` with A=0x1234, B=0x4321, SETTLE=2 -> `gnt`=0001 in cycle 1; `ack` in cycle 4 with `sum_out`=0x5555, `cout_out`=0, `resp_id`=0.
- Carry/wrap: `req[2]` with A=0xFFFF, B=0x0001 -> `sum_out`=0x0000, `cout_out`=1. Then A=0x8000, B=0x8000 -> 0x0000 with `cout_out`=1.
- Round-robin: all four `req` held high -> `ack` `resp_id` sequence 0,1,2,3,0; `ack` pulses spaced exactly 5 cycles apart (SETTLE=2).
- Pointer wrap: after serving 3, only `req[1]` and `req[3]` high -> 1 served first, then 3.
- Abort: `req[1]` dropped in cycle 2 -> no `ack`, `sum_out` unchanged, IDLE in cycle 3, `ptr`=2.
- Reset mid-EVAL: `rst_n` low in cycle 1 -> all outputs 0 asynchronously. After release, a fresh `req[3]` (0x00FF + 0x0F01 = 0x1000) is served normally.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Client-side bus of the shared-adder arbiter: packed requests/operands in,
// one-hot grant, acknowledge and registered result out.
interface adder_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  ack;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      sum_out;
    logic                  cout_out;
    logic                  busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, ack, resp_id, sum_out, cout_out, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, ack, resp_id, sum_out, cout_out, busy
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin controller sharing one latch-based adder among NREQ requesters:
// grant, hold the adder enabled for SETTLE cycles, capture, acknowledge.
module adder_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_enable,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx;
    logic [IDW-1:0]   cur_r;
    logic [IDW-1:0]   ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [NREQ-1:0]  gnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [IDW:0]     pick_s;
    logic             take_s;
    logic             capture_s;
    logic             release_s;
    logic [IDW-1:0]   next_ptr_s;
    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;

    // Returns {found, index} of the first set request at or above p, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0] res;
        int           idx;
        res = {(IDW + 1){1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NREQ;
            if (r[idx]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    assign pick_s     = rr_pick(bus.req, ptr_r);
    assign next_ptr_s = (cur_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : cur_r + IDW'(1);
    assign op_a_s     = bus.a_in[int'(cur_r) * WIDTH +: WIDTH];
    assign op_b_s     = bus.b_in[int'(cur_r) * WIDTH +: WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state; a dropped request on the granted port abandons the operation.
    always_comb begin
        state_nx  = state_r;
        take_s    = 1'b0;
        capture_s = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s[IDW]) begin
                    state_nx = EVAL;
                    take_s   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            EVAL: begin
                if (!bus.req[cur_r]) begin
                    state_nx  = IDLE;
                    release_s = 1'b1;
                end else if (cnt_r == CW'(SETTLE - 1)) begin
                    state_nx = CAPTURE;
                end else begin
                    state_nx = EVAL;
                end
            end
            CAPTURE: begin
                if (!bus.req[cur_r]) begin
                    state_nx  = IDLE;
                    release_s = 1'b1;
                end else begin
                    state_nx  = RESP;
                    capture_s = 1'b1;
                end
            end
            RESP: begin
                state_nx  = IDLE;
                release_s = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Grant, pointer, settle counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r  <= {IDW{1'b0}};
            ptr_r  <= {IDW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            gnt_r  <= {NREQ{1'b0}};
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            if (take_s) begin
                cur_r <= pick_s[IDW-1:0];
                gnt_r <= {{(NREQ - 1){1'b0}}, 1'b1} << pick_s[IDW-1:0];
                cnt_r <= {CW{1'b0}};
            end else if (release_s) begin
                gnt_r <= {NREQ{1'b0}};
                ptr_r <= next_ptr_s;
            end else if (state_r == EVAL) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (capture_s) begin
                sum_r  <= add_sum;
                cout_r <= add_cout;
            end else begin
                sum_r  <= sum_r;
                cout_r <= cout_r;
            end
        end
    end

    // Operands reach the adder only while it evaluates or holds; latches close in CAPTURE.
    always_comb begin
        add_a      = {WIDTH{1'b0}};
        add_b      = {WIDTH{1'b0}};
        add_enable = 1'b0;
        if (state_r == EVAL || state_r == CAPTURE) begin
            add_a = op_a_s;
            add_b = op_b_s;
        end else begin
            add_a = {WIDTH{1'b0}};
            add_b = {WIDTH{1'b0}};
        end
        add_enable = (state_r == EVAL);
    end

    assign bus.gnt      = gnt_r;
    assign bus.ack      = (state_r == RESP);
    assign bus.resp_id  = cur_r;
    assign bus.sum_out  = sum_r;
    assign bus.cout_out = cout_r;
    assign bus.busy     = (state_r != IDLE);
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: latch adder model, operation-level reference
// model compared every cycle, directed scenarios and randomized traffic.
module tb_adder_share_arbiter;
    localparam int NREQ   = 4;
    localparam int WIDTH  = 16;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_enable;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH:0]   lat_q;

    int n_chk = 0;
    int n_err = 0;

    adder_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_enable (add_enable),
        .add_sum    (add_sum),
        .add_cout   (add_cout)
    );

    always #5 clk = ~clk;

    // Transparent while enabled, holds otherwise, like the real adder.
    always_latch begin
        if (add_enable) lat_q <= {1'b0, add_a} + {1'b0, add_b};
    end
    assign add_sum  = lat_q[WIDTH-1:0];
    assign add_cout = lat_q[WIDTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, tracked by its age in cycles since grant.
    bit        m_active = 1'b0;
    int        m_cur = 0;
    int        m_ptr = 0;
    int        m_age = 0;
    logic [WIDTH:0] m_res = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0; m_cur = 0; m_ptr = 0; m_age = 0; m_res = '0;
            end else if (!m_active) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (bus.req[(m_ptr + k) % NREQ]) begin
                        m_active = 1'b1; m_cur = (m_ptr + k) % NREQ; m_age = 1;
                        break;
                    end
                end
            end else if (m_age <= SETTLE + 1 && !bus.req[m_cur]) begin
                m_active = 1'b0; m_ptr = (m_cur + 1) % NREQ;
            end else if (m_age == SETTLE + 2) begin
                m_active = 1'b0; m_ptr = (m_cur + 1) % NREQ;
            end else begin
                if (m_age == SETTLE + 1)
                    m_res = {1'b0, bus.a_in[m_cur*WIDTH +: WIDTH]} + {1'b0, bus.b_in[m_cur*WIDTH +: WIDTH]};
                m_age++;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        logic [NREQ-1:0]  e_gnt;
        logic [WIDTH-1:0] e_a, e_b;
        bit               e_ack, e_drive;
        forever begin
            @(negedge clk);
            e_gnt   = m_active ? (NREQ'(1) << m_cur) : '0;
            e_ack   = m_active && (m_age == SETTLE + 2);
            e_drive = m_active && (m_age <= SETTLE + 1);
            e_a     = e_drive ? bus.a_in[m_cur*WIDTH +: WIDTH] : '0;
            e_b     = e_drive ? bus.b_in[m_cur*WIDTH +: WIDTH] : '0;
            chk("m_gnt_busy_ack", {26'd0, bus.gnt, bus.busy, bus.ack}, {26'd0, e_gnt, m_active, e_ack});
            chk("m_sum_cout", {15'd0, bus.cout_out, bus.sum_out}, {15'd0, m_res});
            chk("m_add_a", {16'd0, add_a}, {16'd0, e_a});
            chk("m_add_b_en", {15'd0, add_enable, add_b},
                {15'd0, (m_active && m_age <= SETTLE), e_b});
            if (e_ack) chk("m_resp_id", 32'(bus.resp_id), 32'(m_cur));
        end
    end

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.a_in[i*WIDTH +: WIDTH] = a;
        bus.b_in[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic do_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] es, input logic ec);
        int c;
        bit seen;
        @(posedge clk); #1;
        set_ops(i, a, b);
        bus.req[i] = 1'b1;
        c = -1; seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk); c++;
            if (c == 1) chk("op_gnt", 32'(bus.gnt), 32'(4'b0001 << i));
            if (bus.ack) seen = 1'b1;
        end
        chk("op_ack_cycle", 32'(c), 32'(SETTLE + 2));
        chk("op_sum", 32'(bus.sum_out), 32'(es));
        chk("op_cout", 32'(bus.cout_out), 32'(ec));
        chk("op_id", 32'(bus.resp_id), 32'(i));
        @(posedge clk); #1;
        bus.req[i] = 1'b0;
    endtask

    task automatic serve(input logic [NREQ-1:0] mask, input int n, input logic [9:0] ids);
        int c, got, last;
        @(posedge clk); #1;
        bus.req = mask;
        c = -1; got = 0; last = 0;
        while (got < n && c < 100) begin
            @(negedge clk); c++;
            if (bus.ack) begin
                chk("rr_id", 32'(bus.resp_id), 32'(ids[2*got +: 2]));
                if (got == 0) chk("rr_first", 32'(c), 32'(SETTLE + 2));
                else          chk("rr_gap", 32'(c - last), 32'(SETTLE + 3));
                last = c; got++;
            end
        end
        chk("rr_count", 32'(got), 32'(n));
        @(posedge clk); #1;
        bus.req = '0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [WIDTH-1:0] held;
        int c;
        bit seen;
        bus.req = '0; bus.a_in = '0; bus.b_in = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy_ack", {30'd0, bus.busy, bus.ack}, 32'd0);
        chk("rst_id", 32'(bus.resp_id), 32'd0);
        chk("rst_sum", {15'd0, bus.cout_out, bus.sum_out}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        do_op(0, 16'h1234, 16'h4321, 16'h5555, 1'b0);
        do_op(2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        do_op(2, 16'h8000, 16'h8000, 16'h0000, 1'b1);
        do_op(3, 16'h0001, 16'h0002, 16'h0003, 1'b0);

        // Round-robin from pointer 0 with everyone requesting.
        set_ops(0, 16'h1111, 16'h0001); set_ops(1, 16'h2222, 16'h0002);
        set_ops(2, 16'h3333, 16'h0003); set_ops(3, 16'hF000, 16'h1000);
        serve(4'b1111, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});

        // Pointer wrap: serve 3 alone, then 1 and 3 compete.
        do_op(3, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        serve(4'b1010, 2, {6'd0, 2'd3, 2'd1});

        // Abort: requester 1 drops its request in cycle 2.
        held = bus.sum_out;
        @(posedge clk); #1;
        set_ops(1, 16'hAAAA, 16'h5555);
        bus.req[1] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        bus.req[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("abort_idle", {29'd0, bus.busy, bus.ack, |bus.gnt}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_noack", 32'(bus.ack), 32'd0);
            chk("abort_sum", 32'(bus.sum_out), 32'(held));
        end
        serve(4'b0101, 2, {6'd0, 2'd0, 2'd2});

        // Reset in cycle 1 of an operation, then a fresh request.
        @(posedge clk); #1;
        set_ops(3, 16'h00FF, 16'h0F01);
        bus.req[3] = 1'b1;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {28'd0, bus.busy, bus.ack, add_enable, |bus.gnt}, 32'd0);
        chk("mid_rst_data", {bus.cout_out, bus.sum_out, add_a}, 33'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        c = -1; seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk); c++;
            if (bus.ack) seen = 1'b1;
        end
        chk("post_rst_cycle", 32'(c), 32'(SETTLE + 2));
        chk("post_rst_sum", {15'd0, bus.cout_out, bus.sum_out}, 32'h0000_1000);
        chk("post_rst_id", 32'(bus.resp_id), 32'd3);
        @(posedge clk); #1;
        bus.req = '0;

        // Randomized traffic: operands only change while that requester is idle.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_ops(i, rnd_op(), rnd_op());
                    bus.req[i] = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        bus.req = '0;
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
